// File: rtl/bitwave_col_scheduler.sv
// Bit-column scheduler for the 16-lane bit-serial BitWave MAC.
// Converts a group of signed weights to sign-magnitude and issues one MAC
// cycle per (non-zero) magnitude bit-column, LSB first, with optional
// skipping of all-zero columns and a DRAIN cycle to flush the MAC psum stage.
module bitwave_col_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LENGTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   skip_en,
    input  logic                                   w_valid,
    output logic                                   w_ready,
    input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]  w_data,
    input  logic                                   grp_first,
    input  logic                                   grp_last,
    output logic                                   mac_en,
    output logic                                   mac_load_accum,
    output logic [VEC_LENGTH-1:0]                  mac_sign,
    output logic [VEC_LENGTH-1:0]                  mac_w_bit,
    output logic [2:0]                             mac_column_idx,
    output logic                                   result_valid,
    output logic                                   busy,
    output logic [CNT_WIDTH-1:0]                   skip_cnt
);

    localparam int MW = DATA_WIDTH - 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t state_q, state_d;

    logic [VEC_LENGTH-1:0]          sign_q;
    logic [VEC_LENGTH-1:0][MW-1:0]  mag_q;
    logic [MW-1:0]                  rem_q;
    logic                           first_q;
    logic                           gfirst_q;
    logic                           glast_q;
    logic                           load_q;
    logic                           last_d1_q;
    logic                           rv_q;
    logic [CNT_WIDTH-1:0]           skip_q;

    logic [VEC_LENGTH-1:0]          in_sign;
    logic [VEC_LENGTH-1:0][MW-1:0]  in_mag;
    logic [MW-1:0]                  raw_mask;
    logic [MW-1:0]                  acc_mask;
    logic [2:0]                     skipped;
    logic [CNT_WIDTH:0]             skip_sum;
    logic [2:0]                     col_idx;
    logic [MW-1:0]                  col_onehot;
    logic                           last_col;
    logic                           accept;
    logic                           issuing;
    logic [VEC_LENGTH-1:0]          lane_bit;

    // Per-lane sign-magnitude conversion; -128 saturates to magnitude 127.
    // Also selects the current column bit of each registered magnitude.
    genvar gi;
    generate
        for (gi = 0; gi < VEC_LENGTH; gi++) begin : g_lane
            logic [DATA_WIDTH-1:0] neg_w;
            assign neg_w       = ~w_data[gi] + 1'b1;
            assign in_sign[gi] = w_data[gi][DATA_WIDTH-1];
            assign in_mag[gi]  = !in_sign[gi] ? w_data[gi][MW-1:0] :
                                 (w_data[gi] == {1'b1, {MW{1'b0}}}) ? {MW{1'b1}} :
                                 neg_w[MW-1:0];
            assign lane_bit[gi] = mag_q[gi][col_idx];
        end
    endgenerate

    // Column mask of the incoming group plus the number of columns it skips.
    always_comb begin
        raw_mask = '0;
        for (int j = 0; j < VEC_LENGTH; j++) begin
            raw_mask = raw_mask | in_mag[j];
        end
        if (!skip_en) begin
            acc_mask = {MW{1'b1}};
        end else if (raw_mask == '0) begin
            acc_mask = {{(MW-1){1'b0}}, 1'b1};
        end else begin
            acc_mask = raw_mask;
        end
        skipped = '0;
        for (int c = 0; c < MW; c++) begin
            skipped = skipped + {2'b00, ~acc_mask[c]};
        end
        skip_sum = {1'b0, skip_q} + {{(CNT_WIDTH-2){1'b0}}, skipped};
    end

    // Lowest pending column and whether it is the last one of the group.
    always_comb begin
        col_idx = '0;
        for (int c = MW - 1; c >= 0; c--) begin
            if (rem_q[c]) begin
                col_idx = 3'(c);
            end
        end
        col_onehot = {{(MW-1){1'b0}}, 1'b1} << col_idx;
        last_col   = ((rem_q & (rem_q - 1'b1)) == '0);
    end

    assign issuing = (state_q == ISSUE);
    assign accept  = w_valid & w_ready;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; a waiting group is taken on the last column.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   if (last_col) state_d = accept ? ISSUE : DRAIN;
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs towards the MAC and the weight source.
    always_comb begin
        w_ready        = 1'b0;
        mac_en         = 1'b0;
        mac_sign       = '0;
        mac_w_bit      = '0;
        mac_column_idx = '0;
        case (state_q)
            IDLE: begin
                w_ready = reset;
            end
            ISSUE: begin
                w_ready        = reset & last_col;
                mac_en         = 1'b1;
                mac_sign       = sign_q;
                mac_w_bit      = lane_bit;
                mac_column_idx = col_idx;
            end
            DRAIN: begin
                mac_en = 1'b1;
            end
            default: ;
        endcase
    end

    // Group registers, remaining mask, delay flags and skip counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sign_q    <= '0;
            mag_q     <= '0;
            rem_q     <= '0;
            first_q   <= 1'b0;
            gfirst_q  <= 1'b0;
            glast_q   <= 1'b0;
            load_q    <= 1'b0;
            last_d1_q <= 1'b0;
            rv_q      <= 1'b0;
            skip_q    <= '0;
        end else begin
            // Flags use the current group's values before a back-to-back load.
            load_q    <= issuing & first_q & gfirst_q;
            last_d1_q <= issuing & last_col & glast_q;
            rv_q      <= last_d1_q;
            if (accept) begin
                sign_q   <= in_sign;
                mag_q    <= in_mag;
                rem_q    <= acc_mask;
                first_q  <= 1'b1;
                gfirst_q <= grp_first;
                glast_q  <= grp_last;
                skip_q   <= skip_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : skip_sum[CNT_WIDTH-1:0];
            end else if (issuing) begin
                rem_q   <= rem_q & ~col_onehot;
                first_q <= 1'b0;
            end
        end
    end

    assign mac_load_accum = load_q;
    assign result_valid   = rv_q;
    assign busy           = (state_q != IDLE);
    assign skip_cnt       = skip_q;

endmodule

// File: doc/bitwave_col_scheduler.md
# bitwave_col_scheduler

Bit-column scheduler for the 16-lane bit-serial BitWave MAC. Accepts one group of VEC_LENGTH signed weights per handshake and converts them to sign-magnitude. Issues one MAC cycle per non-zero magnitude bit-column, LSB first, skipping all-zero columns. Drives the MAC's `sign`, `w_bit`, `column_idx`, `en` and `load_accum`, and flags when the MAC `result` holds a finished dot product.

## Interface
- DATA_WIDTH, 8, weight width; magnitude has DATA_WIDTH-1 = 7 columns (column_idx 0..6)
- VEC_LENGTH, 16, lanes per group
- CNT_WIDTH, 16, width of skip counter
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- skip_en  in  1  1: issue only non-zero columns; 0: issue all 7 columns
- w_valid  in  1  weight group valid
- w_ready  out  1  scheduler accepts group this cycle
- w_data  in  VEC_LENGTH x DATA_WIDTH  signed two's-complement weights
- grp_first  in  1  group starts a new dot product (MAC loads accum_prev)
- grp_last  in  1  group ends a dot product (raise result_valid)
- mac_en  out  1  to MAC en
- mac_load_accum  out  1  to MAC load_accum
- mac_sign  out  VEC_LENGTH x 1  to MAC sign
- mac_w_bit  out  VEC_LENGTH x 1  to MAC w_bit
- mac_column_idx  out  3  to MAC column_idx
- result_valid  out  1  one-cycle pulse: MAC result is final for a grp_last group
- busy  out  1  state != IDLE
- skip_cnt  out  CNT_WIDTH  saturating count of skipped columns since reset

## Operation
- Accept on w_valid & w_ready. Register per lane: sign = w[7], mag = |w| (7 bits). -128 saturates to mag 127, sign 1.
- Register col_mask[c] = OR over lanes of mag[c]. If skip_en=0 or col_mask=0, col_mask = 7'h7F or 7'h01 respectively. An all-zero group always issues exactly column 0 so load_accum/drain still occur.
- Accept: skip_cnt += 7 - popcount(col_mask), saturating at all-ones.
- FSM states IDLE, ISSUE, DRAIN:
  - IDLE: w_ready=1, mac_en=0; accept -> ISSUE.
  - ISSUE: mac_en=1, mac_column_idx = lowest set bit c of remaining mask, mac_w_bit[j]=mag[j][c], mac_sign[j]=sign[j]; clear bit c. w_ready=1 only when it is the last remaining column. Last column with accept -> ISSUE (new group, back-to-back); without accept -> DRAIN; else stay.
  - DRAIN: mac_en=1, mac_w_bit all 0, mac_sign all 0, mac_column_idx 0, w_ready=0 -> IDLE. Flushes the MAC's internal psum register into the accumulator and leaves it at 0.
- mac_load_accum: asserted the cycle after the first ISSUE cycle of a grp_first group. This aligns with the MAC's one-cycle psum pipeline stage; otherwise 0.
- result_valid: asserted 2 cycles after the last ISSUE cycle of a grp_last group, whether the following cycle is DRAIN or a new group's ISSUE.
- Outputs mac_sign/mac_w_bit/mac_column_idx are 0 in IDLE.

## Timing
- Reset values: state IDLE, w_ready=1 (after reset released), all mac_* 0, result_valid 0, busy 0, skip_cnt 0; delay flags cleared. Reset asserted mid-group aborts immediately; no result_valid for the aborted group.
- Group accepted at edge E0 with N issued columns: ISSUE cycles C1..CN (C1 is the cycle after E0), mac_load_accum in C2 (if grp_first), result_valid in C(N+2).
- Back-to-back throughput: N cycles per group, no bubble; DRAIN only when no group is waiting.
- w_ready is combinational from state and remaining mask; w_data is sampled only on accept.
- skip_en is sampled only at accept; changing it mid-group has no effect on that group.
- Single-column group (N=1): w_ready=1 in its only ISSUE cycle.

## Test plan
- All 16 weights = 5, grp_first=grp_last=1, skip_en=1 -> issue col 0 then col 2 with w_bit all 1, sign all 0; load_accum in C2; result_valid in C4; DRAIN in C3; skip_cnt=5.
- Lane 0 = -3, others 0 -> cols 0,1; mac_sign[0]=1, mac_w_bit[0]=1 in both cycles, other lanes 0; lane 0 = -128 -> 7 cols, mag 127.
- All-zero group -> single col-0 cycle with w_bit all 0, load_accum still asserted, result_valid at C3, skip_cnt += 6.
- skip_en=0 with weights = 1 -> 7 ISSUE cycles, col 0..6 in order, skip_cnt unchanged.
- Two groups back-to-back (first: grp_first=1 grp_last=0 with cols 0,3; second: grp_first=0 grp_last=1 with col 6) -> ISSUE cols 0,3,6 in consecutive cycles, no DRAIN between them, single result_valid 2 cycles after the col-6 cycle.
- reset pulled low during second ISSUE cycle -> all outputs 0 asynchronously; after release: IDLE, w_ready=1, no stray result_valid or load_accum.
